// File: rtl/ex_hazard_controller_if.sv
// Pipeline-side signal bundle for the execute-stage hazard controller.
// The pipeline (master) supplies decode/execute/memory stage information;
// the controller (slave) returns operand forward selects, stalls and flushes.
interface ex_hazard_controller_if;
    // Decode stage
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    // Execute stage
    logic [4:0] ex_rd;
    logic       ex_reg_write;
    logic       ex_mem_read;
    logic       ex_pc_src;
    logic       ex_mc_start;
    logic       mc_done;
    // Memory stage
    logic [4:0] mem_rd;
    logic       mem_reg_write;
    // Controller outputs
    logic [1:0] forward_a;
    logic [1:0] forward_b;
    logic       stall_if;
    logic       stall_id;
    logic       stall_ex;
    logic       flush_id;
    logic       flush_ex;
    logic       mc_timeout;

    modport master (
        output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        output ex_rd, ex_reg_write, ex_mem_read, ex_pc_src, ex_mc_start, mc_done,
        output mem_rd, mem_reg_write,
        input  forward_a, forward_b, stall_if, stall_id, stall_ex,
        input  flush_id, flush_ex, mc_timeout
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        input  ex_rd, ex_reg_write, ex_mem_read, ex_pc_src, ex_mc_start, mc_done,
        input  mem_rd, mem_reg_write,
        output forward_a, forward_b, stall_if, stall_id, stall_ex,
        output flush_id, flush_ex, mc_timeout
    );
endinterface

// File: rtl/ex_hazard_controller.sv
// Execute-stage scheduler for the 5-stage core: registered operand forward
// selects, load-use bubble insertion, branch/jump flush, and a front-end plus
// execute hold while the multi-cycle (mul/div) unit is busy, with a watchdog
// that forces the pipeline back to RUN and raises a sticky error flag.
module ex_hazard_controller #(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 7
) (
    input  logic                   clk,
    input  logic                   reset_n,
    ex_hazard_controller_if.slave  hz
);

    localparam logic [0:0] RUN     = 1'b0;
    localparam logic [0:0] MC_BUSY = 1'b1;

    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_RF  = 2'b00;

    // Last busy-cycle count before the watchdog fires.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MC_TIMEOUT - 1);

    logic [0:0]       state_q, state_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic [1:0]       fwd_a_q, fwd_a_nxt;
    logic [1:0]       fwd_b_q, fwd_b_nxt;
    logic             timeout_q, timeout_nxt;

    logic [1:0] fwd_a_calc, fwd_b_calc;
    logic       load_use;
    logic       stall_if, stall_id, stall_ex, flush_id, flush_ex;

    // Forward select for each operand; the execute-stage producer is newer
    // than the memory-stage one, so it wins when both match.
    always_comb begin
        fwd_a_calc = FWD_RF;
        if (hz.id_valid && hz.id_uses_rs1 && hz.id_rs1 != 5'd0) begin
            if (hz.ex_reg_write && hz.ex_rd == hz.id_rs1)
                fwd_a_calc = FWD_MEM;
            else if (hz.mem_reg_write && hz.mem_rd == hz.id_rs1)
                fwd_a_calc = FWD_WB;
        end

        fwd_b_calc = FWD_RF;
        if (hz.id_valid && hz.id_uses_rs2 && hz.id_rs2 != 5'd0) begin
            if (hz.ex_reg_write && hz.ex_rd == hz.id_rs2)
                fwd_b_calc = FWD_MEM;
            else if (hz.mem_reg_write && hz.mem_rd == hz.id_rs2)
                fwd_b_calc = FWD_WB;
        end
    end

    // A load in execute whose destination a decode operand reads cannot be
    // forwarded in time; the consumer waits one cycle behind a bubble.
    assign load_use = hz.id_valid && hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
                      ((hz.id_uses_rs1 && hz.ex_rd == hz.id_rs1) ||
                       (hz.id_uses_rs2 && hz.ex_rd == hz.id_rs2));

    // Next-state, forward-select and stall/flush decode.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_nxt   = state_q;
        cnt_nxt     = cnt_q;
        fwd_a_nxt   = fwd_a_q;
        fwd_b_nxt   = fwd_b_q;
        timeout_nxt = timeout_q;
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        stall_ex    = 1'b0;
        flush_id    = 1'b0;
        flush_ex    = 1'b0;

        case (state_q)
            RUN: begin
                if (hz.ex_pc_src) begin
                    // Redirect wins; a multi-cycle start on the wrong path is dropped.
                    flush_id  = 1'b1;
                    flush_ex  = 1'b1;
                    fwd_a_nxt = FWD_RF;
                    fwd_b_nxt = FWD_RF;
                end else if (hz.ex_mc_start) begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    stall_ex  = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = MC_BUSY;
                end else if (load_use) begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    flush_ex  = 1'b1;
                    fwd_a_nxt = FWD_RF;
                    fwd_b_nxt = FWD_RF;
                end else begin
                    fwd_a_nxt = fwd_a_calc;
                    fwd_b_nxt = fwd_b_calc;
                end
            end

            MC_BUSY: begin
                if (hz.mc_done || cnt_q == CNT_LAST) begin
                    // Release: the decode instruction advances into execute
                    // this cycle, whether the unit finished or the watchdog fired.
                    state_nxt = RUN;
                    if (!hz.mc_done)
                        timeout_nxt = 1'b1;
                    if (load_use) begin
                        flush_ex  = 1'b1;
                        fwd_a_nxt = FWD_RF;
                        fwd_b_nxt = FWD_RF;
                    end else begin
                        fwd_a_nxt = fwd_a_calc;
                        fwd_b_nxt = fwd_b_calc;
                    end
                end else begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    stall_ex = 1'b1;
                    cnt_nxt  = cnt_q + CNT_W'(1);
                end
            end

            default: state_nxt = RUN;
        endcase
    end

    // State, busy counter, forward selects and sticky timeout flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            fwd_a_q   <= FWD_RF;
            fwd_b_q   <= FWD_RF;
            timeout_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q   <= state_nxt;
            cnt_q     <= cnt_nxt;
            fwd_a_q   <= fwd_a_nxt;
            fwd_b_q   <= fwd_b_nxt;
            timeout_q <= timeout_nxt;
        end
    end

    assign hz.forward_a  = fwd_a_q;
    assign hz.forward_b  = fwd_b_q;
    assign hz.stall_if   = stall_if;
    assign hz.stall_id   = stall_id;
    assign hz.stall_ex   = stall_ex;
    assign hz.flush_id   = flush_id;
    assign hz.flush_ex   = flush_ex;
    assign hz.mc_timeout = timeout_q;

endmodule

// File: tb/tb_ex_hazard_controller.sv
// Directed testbench for ex_hazard_controller: forwarding, load-use bubble,
// branch flush, multi-cycle hold, watchdog timeout and asynchronous reset.
module tb_ex_hazard_controller;

    localparam int MC_TIMEOUT = 8;
    localparam int CNT_W      = 4;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    ex_hazard_controller_if hz ();

    ex_hazard_controller #(
        .MC_TIMEOUT (MC_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .hz      (hz)
    );

    // Control outputs packed as {stall_if, stall_id, stall_ex, flush_id, flush_ex}.
    logic [4:0] ctrl;
    assign ctrl = {hz.stall_if, hz.stall_id, hz.stall_ex, hz.flush_id, hz.flush_ex};

    localparam logic [4:0] C_NONE   = 5'b00000;
    localparam logic [4:0] C_HOLD   = 5'b11100;
    localparam logic [4:0] C_LDUSE  = 5'b11001;
    localparam logic [4:0] C_BRANCH = 5'b00011;

    typedef struct packed {
        logic [4:0] ex_rd;
        logic       ex_wr;
        logic [4:0] mem_rd;
        logic       mem_wr;
        logic       valid;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [1:0] exp_a;
        logic [1:0] exp_b;
    } fwd_vec_t;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        hz.id_valid      = 1'b0;
        hz.id_rs1        = 5'd0;
        hz.id_rs2        = 5'd0;
        hz.id_uses_rs1   = 1'b0;
        hz.id_uses_rs2   = 1'b0;
        hz.ex_rd         = 5'd0;
        hz.ex_reg_write  = 1'b0;
        hz.ex_mem_read   = 1'b0;
        hz.ex_pc_src     = 1'b0;
        hz.ex_mc_start   = 1'b0;
        hz.mc_done       = 1'b0;
        hz.mem_rd        = 5'd0;
        hz.mem_reg_write = 1'b0;
    endtask

    task automatic set_id(input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2);
        hz.id_valid    = 1'b1;
        hz.id_rs1      = rs1;
        hz.id_uses_rs1 = u1;
        hz.id_rs2      = rs2;
        hz.id_uses_rs2 = u2;
    endtask

    task automatic test_reset;
        clear_inputs();
        reset_n = 1'b0;
        #12;
        checks++;
        if (ctrl !== C_NONE) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected %b", ctrl, C_NONE);
        end
        checks++;
        if ({hz.forward_a, hz.forward_b} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_fwd: got %b/%b expected 00/00", hz.forward_a, hz.forward_b);
        end
        checks++;
        if (hz.mc_timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_timeout: got %b expected 0", hz.mc_timeout);
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_forwarding;
        fwd_vec_t v [7] = '{
            '{5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 2'b10, 2'b00},
            '{5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 2'b00, 2'b01},
            '{5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 2'b00, 2'b00},
            '{5'd9, 1'b1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 2'b10, 2'b10},
            '{5'd9, 1'b1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 5'd9, 1'b1, 2'b00, 2'b10},
            '{5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 5'd9, 1'b1, 5'd9, 1'b1, 2'b00, 2'b00},
            '{5'd3, 1'b1, 5'd4, 1'b1, 1'b1, 5'd4, 1'b1, 5'd3, 1'b1, 2'b01, 2'b10}
        };
        for (int i = 0; i < 7; i++) begin
            clear_inputs();
            hz.ex_rd         = v[i].ex_rd;
            hz.ex_reg_write  = v[i].ex_wr;
            hz.mem_rd        = v[i].mem_rd;
            hz.mem_reg_write = v[i].mem_wr;
            set_id(v[i].rs1, v[i].u1, v[i].rs2, v[i].u2);
            hz.id_valid      = v[i].valid;
            #3;
            checks++;
            if (ctrl !== C_NONE) begin
                errors++;
                $display("FAIL fwd_ctrl[%0d]: got %b expected %b", i, ctrl, C_NONE);
            end
            tick();
            checks++;
            if (hz.forward_a !== v[i].exp_a || hz.forward_b !== v[i].exp_b) begin
                errors++;
                $display("FAIL fwd_sel[%0d]: got %b/%b expected %b/%b",
                         i, hz.forward_a, hz.forward_b, v[i].exp_a, v[i].exp_b);
            end
        end
    endtask

    task automatic test_load_use;
        // Plain ALU producer first so forward_b is non-zero beforehand.
        clear_inputs();
        hz.ex_rd = 5'd7;
        hz.ex_reg_write = 1'b1;
        set_id(5'd0, 1'b0, 5'd7, 1'b1);
        tick();
        checks++;
        if (hz.forward_b !== 2'b10) begin
            errors++;
            $display("FAIL lu_pre_fwd_b: got %b expected 10", hz.forward_b);
        end
        // Same producer is now a load.
        hz.ex_mem_read = 1'b1;
        #3;
        checks++;
        if (ctrl !== C_LDUSE) begin
            errors++;
            $display("FAIL lu_ctrl: got %b expected %b", ctrl, C_LDUSE);
        end
        tick();
        checks++;
        if (hz.forward_b !== 2'b00) begin
            errors++;
            $display("FAIL lu_fwd_b: got %b expected 00", hz.forward_b);
        end
        // Bubble in execute, load in memory: single-cycle stall only.
        hz.ex_mem_read   = 1'b0;
        hz.ex_reg_write  = 1'b0;
        hz.ex_rd         = 5'd0;
        hz.mem_rd        = 5'd7;
        hz.mem_reg_write = 1'b1;
        #3;
        checks++;
        if (ctrl !== C_NONE) begin
            errors++;
            $display("FAIL lu_after_ctrl: got %b expected %b", ctrl, C_NONE);
        end
        tick();
        checks++;
        if (hz.forward_b !== 2'b01) begin
            errors++;
            $display("FAIL lu_after_fwd_b: got %b expected 01", hz.forward_b);
        end
    endtask

    task automatic test_branch;
        clear_inputs();
        hz.ex_rd = 5'd5;
        hz.ex_reg_write = 1'b1;
        set_id(5'd5, 1'b1, 5'd0, 1'b0);
        tick();
        hz.ex_pc_src   = 1'b1;
        hz.ex_mc_start = 1'b1;
        #3;
        checks++;
        if (ctrl !== C_BRANCH) begin
            errors++;
            $display("FAIL br_ctrl: got %b expected %b", ctrl, C_BRANCH);
        end
        tick();
        checks++;
        if (hz.forward_a !== 2'b00) begin
            errors++;
            $display("FAIL br_fwd_a: got %b expected 00", hz.forward_a);
        end
        // Still in RUN: nothing held with quiet inputs.
        clear_inputs();
        #3;
        checks++;
        if (ctrl !== C_NONE) begin
            errors++;
            $display("FAIL br_state_run: got %b expected %b", ctrl, C_NONE);
        end
        tick();
    endtask

    task automatic test_multicycle;
        clear_inputs();
        hz.ex_rd = 5'd3;
        hz.ex_reg_write = 1'b1;
        hz.mem_rd = 5'd4;
        hz.mem_reg_write = 1'b1;
        set_id(5'd3, 1'b1, 5'd4, 1'b1);
        tick();
        checks++;
        if (hz.forward_a !== 2'b10 || hz.forward_b !== 2'b01) begin
            errors++;
            $display("FAIL mc_pre_fwd: got %b/%b expected 10/01", hz.forward_a, hz.forward_b);
        end
        // Producers vanish so a non-holding design would load 00/00.
        hz.ex_reg_write  = 1'b0;
        hz.mem_reg_write = 1'b0;
        hz.ex_mc_start   = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #3;
            checks++;
            if (ctrl !== C_HOLD) begin
                errors++;
                $display("FAIL mc_hold_ctrl[%0d]: got %b expected %b", c, ctrl, C_HOLD);
            end
            tick();
            checks++;
            if (hz.forward_a !== 2'b10 || hz.forward_b !== 2'b01) begin
                errors++;
                $display("FAIL mc_hold_fwd[%0d]: got %b/%b expected 10/01",
                         c, hz.forward_a, hz.forward_b);
            end
            hz.ex_mc_start = 1'b0;
        end
        // Cycle 4: result ready, pipeline released with fresh selects.
        hz.mc_done       = 1'b1;
        hz.mem_rd        = 5'd2;
        hz.mem_reg_write = 1'b1;
        set_id(5'd2, 1'b1, 5'd0, 1'b0);
        #3;
        checks++;
        if (ctrl !== C_NONE) begin
            errors++;
            $display("FAIL mc_done_ctrl: got %b expected %b", ctrl, C_NONE);
        end
        tick();
        checks++;
        if (hz.forward_a !== 2'b01 || hz.forward_b !== 2'b00) begin
            errors++;
            $display("FAIL mc_done_fwd: got %b/%b expected 01/00", hz.forward_a, hz.forward_b);
        end
        clear_inputs();
        #3;
        checks++;
        if (ctrl !== C_NONE || hz.mc_timeout !== 1'b0) begin
            errors++;
            $display("FAIL mc_back_run: got %b/%b expected %b/0", ctrl, hz.mc_timeout, C_NONE);
        end
        tick();
    endtask

    task automatic test_timeout;
        clear_inputs();
        hz.ex_mc_start = 1'b1;
        #3;
        checks++;
        if (ctrl !== C_HOLD) begin
            errors++;
            $display("FAIL to_start_ctrl: got %b expected %b", ctrl, C_HOLD);
        end
        tick();
        hz.ex_mc_start = 1'b0;
        // Busy counts 0..MC_TIMEOUT-2 hold; count MC_TIMEOUT-1 releases.
        for (int c = 0; c < MC_TIMEOUT; c++) begin
            #3;
            checks++;
            if (ctrl !== ((c < MC_TIMEOUT - 1) ? C_HOLD : C_NONE) || hz.mc_timeout !== 1'b0) begin
                errors++;
                $display("FAIL to_busy[%0d]: got %b/%b expected %b/0", c, ctrl, hz.mc_timeout,
                         (c < MC_TIMEOUT - 1) ? C_HOLD : C_NONE);
            end
            tick();
        end
        for (int c = 0; c < 2; c++) begin
            #3;
            checks++;
            if (hz.mc_timeout !== 1'b1 || ctrl !== C_NONE) begin
                errors++;
                $display("FAIL to_sticky[%0d]: got %b/%b expected 1/%b", c, hz.mc_timeout, ctrl, C_NONE);
            end
            tick();
        end
        // Short asynchronous reset pulse between clock edges.
        reset_n = 1'b0;
        #1;
        checks++;
        if (hz.mc_timeout !== 1'b0) begin
            errors++;
            $display("FAIL to_async_clear: got %b expected 0", hz.mc_timeout);
        end
        reset_n = 1'b1;
        tick();
        checks++;
        if (hz.mc_timeout !== 1'b0) begin
            errors++;
            $display("FAIL to_after_reset: got %b expected 0", hz.mc_timeout);
        end
    endtask

    task automatic test_reset_mid_busy;
        clear_inputs();
        hz.ex_rd = 5'd5;
        hz.ex_reg_write = 1'b1;
        set_id(5'd5, 1'b1, 5'd0, 1'b0);
        tick();
        hz.ex_reg_write = 1'b0;
        hz.ex_mc_start  = 1'b1;
        tick();
        hz.ex_mc_start = 1'b0;
        tick();
        #1;
        checks++;
        if (ctrl !== C_HOLD || hz.forward_a !== 2'b10) begin
            errors++;
            $display("FAIL rb_busy: got %b/%b expected %b/10", ctrl, hz.forward_a, C_HOLD);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (ctrl !== C_NONE) begin
            errors++;
            $display("FAIL rb_async_ctrl: got %b expected %b", ctrl, C_NONE);
        end
        checks++;
        if (hz.forward_a !== 2'b00 || hz.forward_b !== 2'b00) begin
            errors++;
            $display("FAIL rb_async_fwd: got %b/%b expected 00/00", hz.forward_a, hz.forward_b);
        end
        #1;
        reset_n = 1'b1;
        tick();
        #3;
        checks++;
        if (ctrl !== C_NONE || hz.forward_a !== 2'b00 || hz.forward_b !== 2'b00) begin
            errors++;
            $display("FAIL rb_after: got %b %b/%b expected %b 00/00",
                     ctrl, hz.forward_a, hz.forward_b, C_NONE);
        end
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_multicycle();
        test_timeout();
        test_reset_mid_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
